// File: rtl/pattern_scan_ctrl_pkg.sv
// Shared state encoding and default sizing for the pattern scan controller.
package pattern_scan_ctrl_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int PAT_W_DEF  = 4;
  localparam int CNT_W_DEF  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/pattern_scan_ctrl_seq_detector_prog.sv
// Programmable serial sequence detector: shift history, fill tracking, compare.
module seq_detector_prog
  import pattern_scan_ctrl_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             clear,
  input  logic             en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             match
);

  localparam int BS_W = $clog2(PAT_W + 1);

  logic [PAT_W-2:0] hist_q, hist_d;
  logic [BS_W-1:0]  seen_q, seen_d;
  logic [PAT_W-1:0] window;
  logic             full;

  always_comb begin
    window = {hist_q, bit_in};
    // A match needs PAT_W real bits, counting the one presented this cycle.
    full   = (32'(seen_q) + 32'd1) >= 32'(PAT_W);
    match  = en && full && (window == pattern);
  end

  always_comb begin
    hist_d = hist_q;
    seen_d = seen_q;
    if (clear) begin
      hist_d = '0;
      seen_d = '0;
    end else if (en) begin
      if (match && !overlap) begin
        hist_d = '0;
        seen_d = '0;
      end else begin
        hist_d = window[PAT_W-2:0];
        seen_d = (seen_q == BS_W'(PAT_W)) ? seen_q : seen_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      hist_q <= '0;
      seen_q <= '0;
    end else begin
      hist_q <= hist_d;
      seen_q <= seen_d;
    end
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Job sequencer: accepts a word + pattern, streams it MSB-first into the detector, tallies matches.
//   state    | meaning
//   ST_IDLE  | ready for a job, results of last job held
//   ST_SHIFT | one data bit presented to the detector per cycle
//   ST_DONE  | one-cycle completion pulse
module pattern_scan_ctrl
  import pattern_scan_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PAT_W  = PAT_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [PAT_W-1:0]  pattern,
  input  logic              overlap,
  input  logic              abort,
  output logic              ser_out,
  output logic              busy,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              found,
  output logic [CNT_W-1:0]  first_pos,
  output logic              done
);

  state_e             state_q;
  logic [DATA_W-1:0]  data_q;
  logic [PAT_W-1:0]   pat_q;
  logic               ovl_q;
  logic [CNT_W-1:0]   idx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   first_q;
  logic               found_q;
  logic               ready_q;
  logic               busy_q;
  logic               pulse_q;
  logic               done_q;

  logic               det_clear;
  logic               det_en;
  logic               det_match;

  assign det_clear = (state_q == ST_IDLE) && start_valid;
  // The bit presented in an aborted cycle must not reach the detector.
  assign det_en    = (state_q == ST_SHIFT) && !abort;

  seq_detector_prog #(.PAT_W(PAT_W)) u_det (
    .clk     (clk),
    .clr     (clr),
    .clear   (det_clear),
    .en      (det_en),
    .bit_in  (data_q[DATA_W-1]),
    .pattern (pat_q),
    .overlap (ovl_q),
    .match   (det_match)
  );

  // data_q shifts in zeros, so its MSB is 0 whenever no bit is being presented.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      pat_q   <= '0;
      ovl_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      first_q <= '0;
      found_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_valid) begin
            data_q  <= data_in;
            pat_q   <= pattern;
            ovl_q   <= overlap;
            idx_q   <= '0;
            cnt_q   <= '0;
            first_q <= '0;
            found_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            pulse_q <= 1'b0;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            data_q  <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            data_q  <= {data_q[DATA_W-2:0], 1'b0};
            pulse_q <= det_match;
            if (det_match) begin
              if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
              if (!found_q) begin
                found_q <= 1'b1;
                first_q <= idx_q;
              end
            end
            idx_q <= idx_q + 1'b1;
            if (idx_q == CNT_W'(DATA_W - 1)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          pulse_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pulse_q <= 1'b0;
        end
      endcase
    end
  end

  assign start_ready = ready_q;
  assign busy        = busy_q;
  assign ser_out     = data_q[DATA_W-1];
  assign match_pulse = pulse_q;
  assign match_cnt   = cnt_q;
  assign found       = found_q;
  assign first_pos   = first_q;
  assign done        = done_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl: table of whole jobs plus abort/reset/handshake sequences.
module tb_pattern_scan_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] data_in;
  logic [3:0]  pattern;
  logic        overlap;
  logic        abort;
  logic        ser_out;
  logic        busy;
  logic        match_pulse;
  logic [4:0]  match_cnt;
  logic        found;
  logic [4:0]  first_pos;
  logic        done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pattern_scan_ctrl dut (
    .clk         (clk),
    .clr         (clr),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .data_in     (data_in),
    .pattern     (pattern),
    .overlap     (overlap),
    .abort       (abort),
    .ser_out     (ser_out),
    .busy        (busy),
    .match_pulse (match_pulse),
    .match_cnt   (match_cnt),
    .found       (found),
    .first_pos   (first_pos),
    .done        (done)
  );

  typedef struct {
    logic [15:0] data;
    logic [3:0]  pat;
    logic        ovl;
    logic [15:0] mask;   // bit i set = match expected with last bit at idx i
    logic [4:0]  cnt;
    logic        fnd;
    logic [4:0]  first;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_job(input vec_t v, input string tag);
    logic [15:0] mask;
    int done_cyc, busy_cnt, ser_err;
    @(negedge clk);
    start_valid = 1'b1;
    data_in = v.data;
    pattern = v.pat;
    overlap = v.ovl;
    chk({tag, " ready_before"}, 32'(start_ready), 32'd1);
    @(negedge clk);
    // Scramble the inputs once accepted; the job must not notice.
    start_valid = 1'b0;
    data_in = ~v.data;
    pattern = ~v.pat;
    overlap = ~v.ovl;
    mask = '0;
    done_cyc = 0;
    busy_cnt = 0;
    ser_err = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (match_pulse && cyc >= 2 && cyc <= 17) mask[cyc-2] = 1'b1;
      if (busy) busy_cnt++;
      if (cyc <= 16 && ser_out !== v.data[16-cyc]) ser_err++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    chk({tag, " done_cycle"}, 32'(done_cyc), 32'd17);
    chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'd16);
    chk({tag, " ser_out_errs"}, 32'(ser_err), 32'd0);
    chk({tag, " pulse_mask"}, 32'(mask), 32'(v.mask));
    chk({tag, " match_cnt"}, 32'(match_cnt), 32'(v.cnt));
    chk({tag, " found"}, 32'(found), 32'(v.fnd));
    chk({tag, " first_pos"}, 32'(first_pos), 32'(v.first));
    chk({tag, " ready_in_done"}, 32'(start_ready), 32'd0);
    @(negedge clk);
    chk({tag, " ready_after"}, 32'(start_ready), 32'd1);
    chk({tag, " done_width"}, 32'(done), 32'd0);
    chk({tag, " cnt_held"}, 32'(match_cnt), 32'(v.cnt));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt;
    vecs[0] = '{16'hAA00, 4'b1010, 1'b1, 16'h00A8, 5'd3,  1'b1, 5'd3};
    vecs[1] = '{16'hAA00, 4'b1010, 1'b0, 16'h0088, 5'd2,  1'b1, 5'd3};
    vecs[2] = '{16'hFFFF, 4'b1111, 1'b1, 16'hFFF8, 5'd13, 1'b1, 5'd3};
    vecs[3] = '{16'hFFFF, 4'b1111, 1'b0, 16'h8888, 5'd4,  1'b1, 5'd3};
    vecs[4] = '{16'h0000, 4'b1010, 1'b1, 16'h0000, 5'd0,  1'b0, 5'd0};
    vecs[5] = '{16'h1234, 4'b0011, 1'b1, 16'h0800, 5'd1,  1'b1, 5'd11};

    clr = 1'b0;
    start_valid = 1'b0;
    data_in = '0;
    pattern = '0;
    overlap = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    chk("rst start_ready", 32'(start_ready), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst outputs", {ser_out, match_pulse, found, done, match_cnt, first_pos}, 32'd0);

    for (int i = 0; i < 6; i++) run_job(vecs[i], $sformatf("vec%0d", i));

    // Abort in the fifth SHIFT cycle (idx 4).
    @(negedge clk);
    start_valid = 1'b1; data_in = 16'hAA00; pattern = 4'b1010; overlap = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort ready", 32'(start_ready), 32'd1);
    chk("abort done", 32'(done), 32'd0);
    chk("abort match_cnt", 32'(match_cnt), 32'd1);
    chk("abort found_first", {found, first_pos}, {1'b1, 5'd3});
    dcnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    chk("abort no_done", 32'(dcnt), 32'd0);
    run_job(vecs[0], "after_abort");

    // Synchronous clear in mid-job.
    @(negedge clk);
    start_valid = 1'b1; data_in = 16'hFFFF; pattern = 4'b1111; overlap = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_clr busy", 32'(busy), 32'd1);
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    chk("clr ready", 32'(start_ready), 32'd1);
    chk("clr outputs", {busy, ser_out, match_pulse, found, done, match_cnt, first_pos}, 32'd0);
    run_job(vecs[3], "after_clr");

    // start_valid held through SHIFT/DONE; inputs change mid-job.
    @(negedge clk);
    start_valid = 1'b1; data_in = 16'hAA00; pattern = 4'b1010; overlap = 1'b1;
    @(negedge clk);
    repeat (9) @(negedge clk);
    data_in = 16'hFFFF; pattern = 4'b1111;
    repeat (7) @(negedge clk);
    chk("hold done_c17", 32'(done), 32'd1);
    chk("hold ready_c17", 32'(start_ready), 32'd0);
    chk("hold cnt_job1", 32'(match_cnt), 32'd3);
    @(negedge clk);
    chk("hold idle_c18", {busy, start_ready}, 32'b01);
    @(negedge clk);
    chk("hold accept_c19", {busy, start_ready}, 32'b10);
    start_valid = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (done) begin
        dcnt = 1;
        break;
      end
      @(negedge clk);
    end
    chk("hold job2_done", 32'(dcnt), 32'd1);
    chk("hold job2_cnt", 32'(match_cnt), 32'd13);
    chk("hold job2_first", 32'(first_pos), 32'd3);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
Name: pattern_scan_ctrl

Overview:
Sequencer that accepts a parallel word and pattern via a valid/ready handshake, then feeds the word MSB-first into a programmable serial sequence detector, one bit per clock. It counts detector matches and records whether and where the first match occurred. It finishes with a one-cycle done pulse. It sits in front of the serial pattern-detection datapath and owns its sequencing, configuration and clearing.

Parameters:
DATA_W, 16, width of the word scanned per job
PAT_W, 4, pattern length in bits (2..DATA_W)
CNT_W, 5, width of match_cnt and first_pos; must satisfy 2^CNT_W > DATA_W

Ports:
clk  in  1  clock, rising edge
clr  in  1  reset, synchronous, active-low
start_valid  in  1  job request
start_ready  out  1  controller can accept a job
data_in  in  DATA_W  word to scan, sampled on accept
pattern  in  PAT_W  pattern to detect, MSB = first bit, sampled on accept
overlap  in  1  1 = overlapping detection, 0 = non-overlapping; sampled on accept
abort  in  1  cancel the running job
ser_out  out  1  bit currently presented to the detector (observability)
busy  out  1  job in progress (SHIFT state)
match_pulse  out  1  one-cycle pulse per detected match
match_cnt  out  CNT_W  matches in current/last job
found  out  1  at least one match in current/last job
first_pos  out  CNT_W  bit index (0 = MSB) of last bit of first match
done  out  1  one-cycle pulse at job completion

Behaviour:
- Reset (clr=0 at a rising edge): state IDLE; detector history and bit counter cleared. All outputs 0 except start_ready, which is 1 from the first cycle after reset. clr takes priority over every other input, including in mid-job.
- States: IDLE, SHIFT, DONE.
- IDLE: start_ready=1, busy=0.
  - On start_valid=1 at an edge: latch data_in, pattern and overlap.
  - Clear match_cnt, found, first_pos, detector history and bits_seen; set idx=0; go to SHIFT.
  - Inputs changed after accept have no effect on the running job.
- SHIFT: busy=1, start_ready=0, ser_out = data_reg[DATA_W-1-idx].
  - Window = {history[PAT_W-2:0], ser_out}.
  - A match occurs when bits_seen+1 >= PAT_W and window == pattern_reg.
  - At the clock edge ending the cycle:
    - history shifts in ser_out.
    - bits_seen increments, saturating at PAT_W.
    - If a match occurred: match_pulse=1 for the next cycle and match_cnt increments, saturating at all-ones. If found was 0, set found=1 and first_pos=idx.
    - Non-overlap mode: on a match, clear history and bits_seen.
  - idx increments; after idx == DATA_W-1, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, start_ready=0, then IDLE.
  - The match from the last bit is visible (match_pulse, match_cnt) in the DONE cycle.
- Latency: accept at edge E0 → SHIFT for cycles 1..DATA_W → DONE in cycle DATA_W+1 → ready again in cycle DATA_W+2.
- abort=1 sampled in SHIFT: go to IDLE at that edge.
  - No done pulse.
  - The bit presented in that cycle is not evaluated.
  - match_cnt, found and first_pos hold partial values.
  - abort is ignored in IDLE and DONE.
- start_valid in SHIFT or DONE: not accepted and not queued; the requester must hold it until start_ready.
- Outside SHIFT, ser_out=0 and match_pulse=0, except for the DONE-cycle match_pulse from the last bit.
- Results hold after done until the next accepted job.

Decomposition:
- Shared package: state encodings ST_IDLE/ST_SHIFT/ST_DONE and the default DATA_W/PAT_W/CNT_W constants.
- One sub-module, seq_detector_prog, holds the history register, bits_seen, the compare, overlap handling and the sync clear.
  - Inputs: clk, clr, clear, en, bit_in, pattern, overlap.
  - Output: match (combinational).
- The controller owns the FSM, idx, the result registers and the handshake.

Test Plan:
- pattern=4'b1010, data=16'hAA00, overlap=1 → matches at idx 3, 5, 7; match_cnt=3, found=1, first_pos=3; done exactly 17 cycles after the accept edge.
- Same job with overlap=0 → matches at idx 3 and 7; match_cnt=2, first_pos=3.
- pattern=4'b1111, data=16'hFFFF → overlap=1 gives match_cnt=13; overlap=0 gives match_cnt=4; first_pos=3 in both.
- pattern=4'b1010, data=16'h0000 → no match_pulse; match_cnt=0, found=0, first_pos=0; done still asserted in cycle 17.
- AA00/1010/overlap=1 with abort=1 in the 5th SHIFT cycle (idx 4) → IDLE next cycle, no done, match_cnt=1, start_ready=1. A new job is then accepted normally.
- Mid-SHIFT clr=0 for one edge → all outputs 0 and IDLE.
  - start_valid held high through SHIFT and DONE is accepted only in the first IDLE cycle.
  - Changing pattern during SHIFT does not alter the result.
